spu_local_store: RTL and testbench

- Local-store responder for the Cell SPU Lite core: the memory end of the core's memread/memwrite/adr/writedata/memdata interface.
- Serves word accesses (instruction fetch, scalar data) and quadword accesses (LQX/STQX) from one shared quadword-organised array.
- Reads return after a fixed pipelined latency. Writes commit at the accepting clock edge.

---
 rtl/spu_local_store_if.sv | 29 ++
 rtl/spu_local_store.sv | 139 +++++++++++++
 tb/tb_spu_local_store.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/spu_local_store_if.sv
// Request/response bundle between the SPU core and its local store.
// The core drives requests through the master modport; the store answers through the slave modport.
interface spu_local_store_if #(
  parameter int WIDTH  = 32,
  parameter int QWIDTH = 4 * WIDTH
);
  logic              memread;
  logic              memwrite;
  logic              qwread;
  logic              qwwrite;
  logic [WIDTH-1:0]  adr;
  logic [WIDTH-1:0]  writedata;
  logic [QWIDTH-1:0] qwwritedata;
  logic [WIDTH-1:0]  memdata;
  logic [QWIDTH-1:0] qwdata;
  logic              rdvalid;
  logic              rdqw;
  logic              err;

  modport master (
    output memread, memwrite, qwread, qwwrite, adr, writedata, qwwritedata,
    input  memdata, qwdata, rdvalid, rdqw, err
  );

  modport slave (
    input  memread, memwrite, qwread, qwwrite, adr, writedata, qwwritedata,
    output memdata, qwdata, rdvalid, rdqw, err
  );
endinterface

// File: rtl/spu_local_store.sv
// Quadword-organised local store serving word and quadword accesses.
// Writes commit at the accepting edge; reads return through a LATENCY-deep pipeline.
module spu_local_store #(
  parameter int WIDTH   = 32,
  parameter int QWIDTH  = 4 * WIDTH,
  parameter int ADRBITS = 12,
  parameter int LATENCY = 2
) (
  input logic               clk,
  input logic               reset,
  spu_local_store_if.slave  bus
);
  localparam int IDXW = ADRBITS - 4;
  localparam int ROWS = 2 ** IDXW;

  logic [QWIDTH-1:0] mem_q [ROWS];

  logic [IDXW-1:0] rowIdx;
  logic [1:0]      lane;
  logic            unusedAdrBits;
  assign rowIdx        = bus.adr[ADRBITS-1:4];
  assign lane          = bus.adr[3:2];
  assign unusedAdrBits = ^{bus.adr[WIDTH-1:ADRBITS], bus.adr[1:0]};

  logic       doQwWrite, doWordWrite, doRead, readQw, conflict;
  logic [2:0] reqCount;

  // Priority qwwrite > memwrite > qwread > memread; nothing is accepted while in reset.
  always_comb begin
    doQwWrite   = 1'b0;
    doWordWrite = 1'b0;
    doRead      = 1'b0;
    readQw      = 1'b0;
    conflict    = 1'b0;
    reqCount    = {2'b00, bus.qwwrite} + {2'b00, bus.memwrite}
                + {2'b00, bus.qwread} + {2'b00, bus.memread};
    if (reset) begin
      doQwWrite   = bus.qwwrite;
      doWordWrite = !bus.qwwrite && bus.memwrite;
      doRead      = !bus.qwwrite && !bus.memwrite && (bus.qwread || bus.memread);
      readQw      = bus.qwread;
      conflict    = reqCount > 3'd1;
    end
  end

  // Array contents survive reset; lane 0 is the most significant word.
  always_ff @(posedge clk) begin
    if (doQwWrite) begin
      mem_q[rowIdx] <= bus.qwwritedata;
    end else if (doWordWrite) begin
      for (int l = 0; l < 4; l++) begin
        if (lane == 2'(l)) begin
          mem_q[rowIdx][(3-l)*WIDTH +: WIDTH] <= bus.writedata;
        end
      end
    end
  end

  logic [LATENCY-1:0] pipeValid_q;
  logic [LATENCY-1:0] pipeQw_q;
  logic [1:0]         pipeLane_q [LATENCY];
  logic [QWIDTH-1:0]  pipeRow_q  [LATENCY];

  always_ff @(posedge clk) begin
    if (!reset) begin
      pipeValid_q <= '0;
    end else begin
      pipeValid_q[0] <= doRead;
      for (int i = 1; i < LATENCY; i++) begin
        pipeValid_q[i] <= pipeValid_q[i-1];
      end
    end
  end

  // Payload needs no reset: it is only consumed alongside a valid bit.
  always_ff @(posedge clk) begin
    pipeQw_q[0]   <= readQw;
    pipeLane_q[0] <= lane;
    pipeRow_q[0]  <= mem_q[rowIdx];
    for (int i = 1; i < LATENCY; i++) begin
      pipeQw_q[i]   <= pipeQw_q[i-1];
      pipeLane_q[i] <= pipeLane_q[i-1];
      pipeRow_q[i]  <= pipeRow_q[i-1];
    end
  end

  logic              rdvalid_q, rdvalid_d;
  logic              rdqw_q, rdqw_d;
  logic              err_q, err_d;
  logic [WIDTH-1:0]  memdata_q, memdata_d;
  logic [QWIDTH-1:0] qwdata_q, qwdata_d;
  logic [WIDTH-1:0]  tailWord;
  logic [QWIDTH-1:0] tailRow;

  always_comb begin
    tailRow = pipeRow_q[LATENCY-1];
    case (pipeLane_q[LATENCY-1])
      2'd0:    tailWord = tailRow[4*WIDTH-1:3*WIDTH];
      2'd1:    tailWord = tailRow[3*WIDTH-1:2*WIDTH];
      2'd2:    tailWord = tailRow[2*WIDTH-1:WIDTH];
      default: tailWord = tailRow[WIDTH-1:0];
    endcase
    rdvalid_d = pipeValid_q[LATENCY-1];
    rdqw_d    = pipeValid_q[LATENCY-1] && pipeQw_q[LATENCY-1];
    err_d     = conflict;
    memdata_d = memdata_q;
    qwdata_d  = qwdata_q;
    // The data bus not addressed by this response keeps its previous value.
    if (pipeValid_q[LATENCY-1]) begin
      if (pipeQw_q[LATENCY-1]) begin
        qwdata_d = tailRow;
      end else begin
        memdata_d = tailWord;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rdvalid_q <= 1'b0;
      rdqw_q    <= 1'b0;
      err_q     <= 1'b0;
      memdata_q <= '0;
      qwdata_q  <= '0;
    end else begin
      rdvalid_q <= rdvalid_d;
      rdqw_q    <= rdqw_d;
      err_q     <= err_d;
      memdata_q <= memdata_d;
      qwdata_q  <= qwdata_d;
    end
  end

  assign bus.rdvalid = rdvalid_q;
  assign bus.rdqw    = rdqw_q;
  assign bus.err     = err_q;
  assign bus.memdata = memdata_q;
  assign bus.qwdata  = qwdata_q;
endmodule

// File: tb/tb_spu_local_store.sv
// Randomised scoreboard bench for spu_local_store against a word-array reference model.
module tb_spu_local_store;
  localparam int LAT = 2;

  logic clk;
  logic reset;

  spu_local_store_if #(.WIDTH(32), .QWIDTH(128)) ifc ();

  spu_local_store #(
    .WIDTH(32), .QWIDTH(128), .ADRBITS(12), .LATENCY(LAT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int unsigned acc;
    int unsigned due;
    bit          isQw;
    logic [127:0] qd;
    logic [31:0]  wd;
  } readExp_t;

  readExp_t    readQ[$];
  int unsigned errQ[$];
  logic [31:0] model [1024];

  int unsigned cycle = 0;
  logic        rstAtEdge = 1'b1;
  bit          started = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0]  lastW = '0;
  logic [127:0] lastQ = '0;

  always @(posedge clk) begin
    cycle     <= cycle + 1;
    rstAtEdge <= reset;
  end

  task automatic compare(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cycle, act, exp);
    end
  endtask

  // Drives one request cycle; expected responses are pushed for the edge that will accept it.
  task automatic applyStimulus(input bit rst, input bit mr, input bit mw, input bit qr,
                               input bit qw, input logic [31:0] a, input logic [31:0] wd,
                               input logic [127:0] qd);
    int unsigned acc;
    int          w;
    int          base;
    readExp_t    e;
    acc = cycle + 1;
    reset           = rst;
    ifc.memread     = mr;
    ifc.memwrite    = mw;
    ifc.qwread      = qr;
    ifc.qwwrite     = qw;
    ifc.adr         = a;
    ifc.writedata   = wd;
    ifc.qwwritedata = qd;
    if (rst) begin
      w    = int'(a[11:2]);
      base = int'(a[11:4]) * 4;
      if (int'(mr) + int'(mw) + int'(qr) + int'(qw) > 1) errQ.push_back(acc);
      if (qw) begin
        for (int k = 0; k < 4; k++) model[base + k] = qd[127 - 32*k -: 32];
      end else if (mw) begin
        model[w] = wd;
      end else if (qr || mr) begin
        e.acc  = acc;
        e.due  = acc + LAT;
        e.isQw = qr;
        e.qd   = {model[base], model[base+1], model[base+2], model[base+3]};
        e.wd   = model[w];
        readQ.push_back(e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1, 0, 0, 0, 0, '0, '0, '0);
  endtask

  // Monitor: outputs seen here reflect the most recent rising edge.
  task automatic checkOutput();
    int unsigned n;
    bit          expErr;
    readExp_t    e;
    n = cycle;
    if (rstAtEdge == 1'b0) begin
      started = 1;
      lastW   = '0;
      lastQ   = '0;
      readQ   = readQ.find(x) with (x.acc >= n);
      errQ    = errQ.find(x) with (x > n);
    end
    if (!started) return;

    expErr = (errQ.size() > 0 && errQ[0] == n);
    if (expErr) void'(errQ.pop_front());
    compare("err", {127'b0, ifc.err}, {127'b0, expErr});

    while (readQ.size() > 0 && readQ[0].due < n) begin
      checks++;
      errors++;
      $display("[TB] FAIL missing_read due %0d at cycle %0d: got no rdvalid expected rdvalid", readQ[0].due, n);
      void'(readQ.pop_front());
    end

    if (ifc.rdvalid === 1'b1) begin
      if (readQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL spurious_rdvalid at cycle %0d: got rdvalid=1 expected 0", n);
      end else begin
        e = readQ.pop_front();
        compare("latency", 128'(n), 128'(e.due));
        compare("rdqw", {127'b0, ifc.rdqw}, {127'b0, e.isQw});
        if (e.isQw) begin
          compare("qwdata", ifc.qwdata, e.qd);
          compare("memdata_hold", {96'b0, ifc.memdata}, {96'b0, lastW});
          lastQ = e.qd;
        end else begin
          compare("memdata", {96'b0, ifc.memdata}, {96'b0, e.wd});
          compare("qwdata_hold", ifc.qwdata, lastQ);
          lastW = e.wd;
        end
      end
    end else begin
      compare("rdvalid", {127'b0, ifc.rdvalid}, 128'b0);
      compare("rdqw_idle", {127'b0, ifc.rdqw}, 128'b0);
      compare("memdata_hold", {96'b0, ifc.memdata}, {96'b0, lastW});
      compare("qwdata_hold", ifc.qwdata, lastQ);
    end
  endtask

  always @(negedge clk) checkOutput();

  initial begin
    int          kind;
    bit          mr, mw, qr, qw, rst;
    logic [127:0] qd;

    applyStimulus(0, 0, 0, 0, 0, '0, '0, '0);
    applyStimulus(0, 0, 0, 0, 0, '0, '0, '0);
    applyStimulus(1, 0, 0, 0, 1, 32'h0, '0, 128'hA5A5A5A5_0BADF00D_C0FFEE00_13579BDF);

    // Reads held during reset are ignored; the first one accepted afterwards returns normally.
    for (int i = 0; i < 3; i++) applyStimulus(0, 1, 0, 0, 0, 32'h4, '0, '0);
    applyStimulus(1, 1, 0, 0, 0, 32'h4, '0, '0);
    idle(4);

    applyStimulus(1, 0, 0, 0, 1, 32'h20, '0, 128'h00112233_44556677_8899AABB_CCDDEEFF);
    applyStimulus(1, 0, 0, 1, 0, 32'h2C, '0, '0);
    idle(3);

    applyStimulus(1, 0, 1, 0, 0, 32'h24, 32'hDEADBEEF, '0);
    applyStimulus(1, 0, 0, 1, 0, 32'h20, '0, '0);
    applyStimulus(1, 1, 0, 0, 0, 32'h2B, '0, '0);
    idle(3);

    applyStimulus(1, 0, 1, 0, 0, 32'h1000, 32'h12345678, '0);
    applyStimulus(1, 1, 0, 0, 0, 32'h0000, '0, '0);
    applyStimulus(1, 1, 0, 0, 0, 32'h1000, '0, '0);
    idle(3);

    applyStimulus(1, 1, 1, 0, 0, 32'h40, 32'h5A5A5A5A, '0);
    applyStimulus(1, 1, 0, 0, 0, 32'h40, '0, '0);
    idle(3);

    applyStimulus(1, 1, 0, 0, 0, 32'h40, '0, '0);
    applyStimulus(0, 0, 0, 0, 0, '0, '0, '0);
    idle(3);
    applyStimulus(1, 1, 0, 0, 0, 32'h40, '0, '0);
    idle(3);

    for (int r = 0; r < 256; r++) begin
      qd = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(1, 0, 0, 0, 1, 32'(r * 16) | ($urandom & 32'hFFFF_F00F), '0, qd);
    end

    for (int i = 0; i < 3000; i++) begin
      rst  = ($urandom_range(0, 99) != 0);
      kind = int'($urandom_range(0, 9));
      {mr, mw, qr, qw} = 4'b0000;
      case (kind)
        0, 1, 2: mr = 1;
        3, 4:    qr = 1;
        5:       mw = 1;
        6:       qw = 1;
        7:       ;
        default: {mr, mw, qr, qw} = 4'($urandom);
      endcase
      qd = {$urandom, $urandom, $urandom, $urandom};
      applyStimulus(rst, mr, mw, qr, qw, $urandom, $urandom, qd);
    end

    idle(LAT + 4);
    compare("drain_empty", 128'(readQ.size()), 128'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
